msg_sequencer: RTL and testbench
================================

Name: msg_sequencer

Overview:
- Parametrised successor to the fixed single-message character ROM used by the display path.
- Holds N_MSG selectable messages, each up to MAX_LEN characters, and streams the selected message one CHAR_W-bit code per accepted transfer.
- Has its own index counter, an inter-character hold gap and a valid/ready handshake toward the display driver.
- Sits between the control FSM (issues start and msg_sel) and the 7-segment/display character decoder.

Parameters:
- CHAR_W, 4, width of a character code.
- MAX_LEN, 8, maximum characters per message; index width IDX_W = clog2(MAX_LEN+1).
- N_MSG, 4, number of messages; select width SEL_W = clog2(N_MSG), minimum 1.
- GAP, 2, idle cycles inserted after each accepted character (0 allowed).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a message; ignored unless idle.
- msg_sel  in  SEL_W  message select, sampled only in the cycle start is accepted.
- char_ready  in  1  downstream accepts the current character.
- char_valid  out  1  caracter/char_idx are valid.
- caracter  out  CHAR_W  current character code.
- char_idx  out  IDX_W  position of current character, 0-based.
- len_string  out  IDX_W  length of the latched message.
- busy  out  1  high from accepted start until the DONE state exits.
- done  out  1  one-cycle pulse after the last character is accepted.

Behaviour:
- Code map: A=0, C=1, D=2, E=3, I=4, N=5, G=6, O=7, R=8, T=10.
- Table: msg0 "ACEITO" = 0,1,3,4,10,7 (len 6). msg1 "NEGADO" = 5,3,6,0,2,7 (len 6). msg2 "ERRO" = 3,8,8,7 (len 4). msg3 "OI" = 7,4 (len 2).
- msg_sel >= 4, or any unused slot when N_MSG > 4, gives len 0.
- Characters beyond MAX_LEN are truncated; len_string saturates at MAX_LEN.
- Reset: state IDLE; char_valid=0, caracter=0, char_idx=0, len_string=0, busy=0, done=0; gap counter=0.
- FSM IDLE: when start=1, latch msg_sel and len_string, and set char_idx=0.
  - If len=0, go to DONE.
  - Otherwise go to SEND, with busy=1 from the next cycle.
- FSM SEND: char_valid=1 and caracter=table[sel][char_idx].
  - caracter and char_idx hold stable until char_ready=1.
  - On char_valid & char_ready: char_valid drops next cycle.
  - If char_idx == len-1, go to DONE.
  - Else if GAP=0, go to SEND with char_idx+1, giving back-to-back transfers.
  - Else go to HOLD with the counter loaded to GAP.
- FSM HOLD: char_valid=0. Decrement the counter each cycle. When it reaches 1, go to SEND with char_idx+1. HOLD lasts exactly GAP cycles.
- FSM DONE: done=1 for exactly one cycle, char_valid=0, busy=1. Next cycle go to IDLE with busy=0; char_idx and len_string hold their last values.
- Latency: start at cycle t gives char_valid=1 at t+1. Each accepted character is followed by GAP cycles before the next one.
- start while busy: ignored, with no effect on sel, index or length.
- msg_sel changes mid-message: no effect.
- char_ready=1 while char_valid=0: no effect.
- rst_n asserted mid-message: immediate return to reset values, with no done pulse.

Optional Feature:
- LOOP_EN defined: in SEND, acceptance of the last character wraps char_idx to 0 (through HOLD if GAP>0) instead of entering DONE.
  - The message repeats until start is sampled high while busy; that request finishes after the current accepted character through DONE.
  - done pulses only on that exit.
- LOOP_EN undefined: single pass as described; start while busy is ignored.

Test Plan:
- Reset, then start with msg_sel=0, char_ready=1, GAP=2 -> caracter 0,1,3,4,10,7 at char_idx 0..5, each valid one cycle, 2 idle cycles between, done pulse 1 cycle after idx 5, len_string=6.
- msg_sel=2 with char_ready low 3 cycles on idx 1 -> caracter=8, char_idx=1 held stable 3 cycles; sequence 3,8,8,7 completes, done once.
- msg_sel=3 with start re-pulsed and msg_sel=1 during the transfer -> output stays 7,4, len 2, no restart.
- N_MSG=8 with msg_sel=5 -> char_valid never rises; done pulses at t+1; busy high 1 cycle.
- Drop rst_n while sending msg1 at idx 3 -> all outputs 0 asynchronously; no done; a fresh start replays from idx 0.
- LOOP_EN with msg3 -> 7,4,7,4,...; start while busy -> finishes at the next accepted character, then done.

Source files
------------

// File: rtl/msg_sequencer.sv
// msg_sequencer: streams one of N_MSG fixed character messages over a valid/ready link.
// Optional feature LOOP_EN: repeat the message until start is seen again while busy.
module msg_sequencer #(
  parameter int CHAR_W  = 4,
  parameter int MAX_LEN = 8,
  parameter int N_MSG   = 4,
  parameter int GAP     = 2,
  localparam int IDX_W  = $clog2(MAX_LEN + 1),
  localparam int SEL_W  = (N_MSG > 1) ? $clog2(N_MSG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  msg_sel,
  input  logic              char_ready,
  output logic              char_valid,
  output logic [CHAR_W-1:0] caracter,
  output logic [IDX_W-1:0]  char_idx,
  output logic [IDX_W-1:0]  len_string,
  output logic              busy,
  output logic              done,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a character transfers on any rising edge where char_valid && char_ready;
  // caracter/char_idx stay stable while char_valid is high and char_ready is low.

  localparam int CNT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic [CHAR_W-1:0]  r_char;
  logic               r_busy;
  logic               r_done;
`ifdef LOOP_EN
  logic               r_stop;
`endif

  logic               w_last;
  logic               w_finish;
  logic [IDX_W-1:0]   w_next_idx;
  logic [IDX_W-1:0]   w_len_in;

  // Messages are nibble-packed, character 0 in the least significant nibble.
  function automatic logic [CHAR_W-1:0] f_char(input logic [SEL_W-1:0] sel,
                                               input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    case (int'(sel))
      0:       w = 32'h007A_4310;
      1:       w = 32'h0072_0635;
      2:       w = 32'h0000_7883;
      3:       w = 32'h0000_0047;
      default: w = 32'h0000_0000;
    endcase
    if (int'(sel) >= N_MSG) w = 32'h0000_0000;
    w = w >> (4 * int'(idx));
    return CHAR_W'(w[3:0]);
  endfunction

  function automatic logic [IDX_W-1:0] f_len(input logic [SEL_W-1:0] sel);
    int raw;
    case (int'(sel))
      0, 1:    raw = 6;
      2:       raw = 4;
      3:       raw = 2;
      default: raw = 0;
    endcase
    if (int'(sel) >= N_MSG) raw = 0;
    if (raw > MAX_LEN) raw = MAX_LEN;
    return IDX_W'(raw);
  endfunction

  always_comb begin
    w_len_in   = f_len(msg_sel);
    w_last     = (r_idx == r_len - IDX_W'(1));
`ifdef LOOP_EN
    w_next_idx = w_last ? '0 : r_idx + IDX_W'(1);
    w_finish   = r_stop | start;
`else
    w_next_idx = r_idx + IDX_W'(1);
    w_finish   = w_last;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_char  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef LOOP_EN
      r_stop  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel  <= msg_sel;
            r_len  <= w_len_in;
            r_idx  <= '0;
            r_busy <= 1'b1;
`ifdef LOOP_EN
            r_stop <= 1'b0;
`endif
            if (w_len_in == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SEND;
              r_valid <= 1'b1;
              r_char  <= f_char(msg_sel, '0);
            end
          end
        end
        S_SEND: begin
`ifdef LOOP_EN
          if (start) r_stop <= 1'b1;
`endif
          if (char_ready) begin
            if (w_finish) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else if (GAP == 0) begin
              r_idx  <= w_next_idx;
              r_char <= f_char(r_sel, w_next_idx);
            end else begin
              r_state <= S_HOLD;
              r_valid <= 1'b0;
              r_cnt   <= CNT_W'(GAP);
            end
          end
        end
        S_HOLD: begin
`ifdef LOOP_EN
          if (start) r_stop <= 1'b1;
`endif
          // The cycle that sees a count of 1 is the last hold cycle.
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_SEND;
            r_valid <= 1'b1;
            r_idx   <= w_next_idx;
            r_char  <= f_char(r_sel, w_next_idx);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign char_valid  = r_valid;
  assign caracter    = r_char;
  assign char_idx    = r_idx;
  assign len_string  = r_len;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_msg_sequencer.sv
// Bench for msg_sequencer: a default instance (4 messages, GAP=2) and an
// 8-slot instance with GAP=0, checked against messages rebuilt from their letters.
module tb_msg_sequencer;

  localparam int CHAR_W  = 4;
  localparam int MAX_LEN = 8;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_req = 1'b0;
  logic [2:0] sel_req = 3'd0;
  logic char_ready = 1'b0;
  logic use8 = 1'b0;

  logic start4, start8;
  logic [1:0] msg_sel4;
  logic [2:0] msg_sel8;
  logic valid4, valid8, busy4, busy8, done4, done8;
  logic [CHAR_W-1:0] char4, char8;
  logic [IDX_W-1:0] idx4, idx8, len4, len8;
  logic [1:0] dbg4, dbg8;

  logic o_valid, o_busy, o_done;
  logic [CHAR_W-1:0] o_char;
  logic [IDX_W-1:0] o_idx, o_len;

  logic [CHAR_W-1:0] exp_q[$];
  int n_asrt = 0;
  int n_fail = 0;

  assign start4   = start_req & ~use8;
  assign start8   = start_req & use8;
  assign msg_sel4 = sel_req[1:0];
  assign msg_sel8 = sel_req;
  assign o_valid  = use8 ? valid8 : valid4;
  assign o_busy   = use8 ? busy8  : busy4;
  assign o_done   = use8 ? done8  : done4;
  assign o_char   = use8 ? char8  : char4;
  assign o_idx    = use8 ? idx8   : idx4;
  assign o_len    = use8 ? len8   : len4;

  msg_sequencer #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .N_MSG(4), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start4), .msg_sel(msg_sel4),
    .char_ready(char_ready), .char_valid(valid4), .caracter(char4),
    .char_idx(idx4), .len_string(len4), .busy(busy4), .done(done4),
    .o_dbg_state(dbg4)
  );

  msg_sequencer #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .N_MSG(8), .GAP(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .msg_sel(msg_sel8),
    .char_ready(char_ready), .char_valid(valid8), .caracter(char8),
    .char_idx(idx8), .len_string(len8), .busy(busy8), .done(done8),
    .o_dbg_state(dbg8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int code_of(input byte c);
    case (c)
      "A": return 0;
      "C": return 1;
      "D": return 2;
      "E": return 3;
      "I": return 4;
      "N": return 5;
      "G": return 6;
      "O": return 7;
      "R": return 8;
      "T": return 10;
      default: return 15;
    endcase
  endfunction

  task automatic build_expected(input int sel, input int n_msg);
    string s;
    s = "";
    exp_q = {};
    if (sel < n_msg) begin
      case (sel)
        0: s = "ACEITO";
        1: s = "NEGADO";
        2: s = "ERRO";
        3: s = "OI";
        default: s = "";
      endcase
    end
    for (int i = 0; i < s.len() && i < MAX_LEN; i++) exp_q.push_back(CHAR_W'(code_of(s[i])));
  endtask

  // Runs one message from start to the cycle after done, checking order,
  // positions, gap timing, stability under stalls, busy and the done pulse.
  task automatic run_msg(input int sel, input bit on8, input int stall_idx,
                         input bit rnd_ready, input bit disturb);
    int exp_len, gap, pos, cyc, last_acc, stall_left;
    bit first_seen, finished;
    use8 = on8;
    gap = on8 ? 0 : 2;
    build_expected(sel, on8 ? 8 : 4);
    exp_len = exp_q.size();
    pos = 0; cyc = 1; last_acc = 0; stall_left = 3; first_seen = 0; finished = 0;
    @(posedge clk); #1;
    start_req = 1'b1; sel_req = 3'(sel); char_ready = 1'b0;
    @(posedge clk); #1;
    start_req = 1'b0;
    while (cyc < 100 && !finished) begin
      char_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pos == stall_idx && stall_left > 0) char_ready = 1'b0;
      if (disturb && cyc == 2) begin
        start_req = 1'b1; sel_req = 3'd1;
      end else begin
        start_req = 1'b0;
      end
      @(negedge clk);
      chk("busy_active", o_busy, 1);
      chk("len_string", o_len, exp_len);
      if (o_valid === 1'b1) begin
        chk("valid_in_range", (pos < exp_len), 1);
        if (!first_seen) begin
          chk("valid_timing", cyc, (pos == 0) ? 1 : last_acc + gap + 1);
          first_seen = 1;
        end
        if (pos < exp_len) chk("caracter", o_char, exp_q[pos]);
        chk("char_idx", o_idx, pos);
        if (char_ready) begin
          pos++; last_acc = cyc; first_seen = 0;
        end else if (pos == stall_idx && stall_left > 0) begin
          stall_left--;
        end
      end
      if (o_done === 1'b1) begin
        chk("done_count", pos, exp_len);
        chk("done_timing", cyc, (exp_len == 0) ? 1 : last_acc + 1);
        finished = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_req = 1'b0;
    chk("msg_timeout", finished, 1);
    @(negedge clk);
    chk("post_busy", o_busy, 0);
    chk("post_done", o_done, 0);
    chk("post_valid", o_valid, 0);
    chk("post_idx_hold", o_idx, (exp_len == 0) ? 0 : exp_len - 1);
    chk("post_len_hold", o_len, exp_len);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_char"},  o_char, 0);
    chk({tag, "_idx"},   o_idx, 0);
    chk({tag, "_len"},   o_len, 0);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_done"},  o_done, 0);
  endtask

  initial begin
    bit found;
    // Reset values on both instances.
    repeat (2) @(negedge clk);
    use8 = 1'b0; #1; chk_zero("reset4");
    use8 = 1'b1; #1; chk_zero("reset8");
    @(negedge clk);
    rst_n = 1'b1;

    // ACEITO with ready held high, then ERRO stalled at idx 1, then OI disturbed.
    run_msg(0, 1'b0, -1, 1'b0, 1'b0);
    run_msg(2, 1'b0, 1, 1'b0, 1'b0);
    run_msg(3, 1'b0, -1, 1'b0, 1'b1);

    // Empty slot on the 8-slot instance, then back-to-back NEGADO with GAP=0.
    run_msg(5, 1'b1, -1, 1'b0, 1'b0);
    run_msg(1, 1'b1, -1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of NEGADO at idx 3.
    use8 = 1'b0;
    @(posedge clk); #1;
    start_req = 1'b1; sel_req = 3'd1; char_ready = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (o_valid === 1'b1 && o_idx === 4'd3) found = 1;
    end
    chk("rst_reach_idx3", found, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    repeat (2) begin
      @(negedge clk);
      chk("midreset_no_done", o_done, 0);
    end
    rst_n = 1'b1;
    run_msg(1, 1'b0, -1, 1'b0, 1'b0);

    // Randomized selections and ready patterns on both instances.
    for (int i = 0; i < 6; i++) begin
      run_msg($urandom_range(0, 3), 1'b0, -1, 1'b1, 1'b0);
      run_msg($urandom_range(0, 7), 1'b1, -1, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
